// File: rtl/sdram_arbiter.sv
// sdram_arbiter
//   Shares one SDRAM controller command port among three masters:
//   0 = video fetcher (top priority), 1 = CPU, 2 = DMA (round-robin between
//   them). Per-master starvation counters let a CPU/DMA master that has
//   waited through STARVE_LIMIT video grants outrank video.
//   One transaction is outstanding at a time.
//
// Ports
//   clk, reset_i         : clock, asynchronous active-high reset
//   mN_req/we/addr/wdata/wmask_i : master N command (held until mN_ack_o)
//   mN_ack_o, mN_rdata_o : completion pulse and read data for master N
//   mem_req/we/addr/wdata/wmask_o : latched command to the controller
//   mem_ack_i, mem_rdata_i : completion pulse and read data from controller
//   grant_o              : current owner 0/1/2, or 3 when idle
module sdram_arbiter #(
  parameter int ADDR_WIDTH   = 22,
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 8
) (
  input  logic                    clk,
  input  logic                    reset_i,
  input  logic                    m0_req_i,
  input  logic                    m0_we_i,
  input  logic [ADDR_WIDTH-1:0]   m0_addr_i,
  input  logic [DATA_WIDTH-1:0]   m0_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m0_wmask_i,
  output logic                    m0_ack_o,
  output logic [DATA_WIDTH-1:0]   m0_rdata_o,
  input  logic                    m1_req_i,
  input  logic                    m1_we_i,
  input  logic [ADDR_WIDTH-1:0]   m1_addr_i,
  input  logic [DATA_WIDTH-1:0]   m1_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m1_wmask_i,
  output logic                    m1_ack_o,
  output logic [DATA_WIDTH-1:0]   m1_rdata_o,
  input  logic                    m2_req_i,
  input  logic                    m2_we_i,
  input  logic [ADDR_WIDTH-1:0]   m2_addr_i,
  input  logic [DATA_WIDTH-1:0]   m2_wdata_i,
  input  logic [DATA_WIDTH/8-1:0] m2_wmask_i,
  output logic                    m2_ack_o,
  output logic [DATA_WIDTH-1:0]   m2_rdata_o,
  output logic                    mem_req_o,
  output logic                    mem_we_o,
  output logic [ADDR_WIDTH-1:0]   mem_addr_o,
  output logic [DATA_WIDTH-1:0]   mem_wdata_o,
  output logic [DATA_WIDTH/8-1:0] mem_wmask_o,
  input  logic                    mem_ack_i,
  input  logic [DATA_WIDTH-1:0]   mem_rdata_i,
  output logic [1:0]              grant_o
);

  localparam int MW = DATA_WIDTH / 8;
  localparam logic [7:0] LIMIT = 8'(STARVE_LIMIT);
  localparam logic [1:0] NONE = 2'd3;

  typedef enum logic {IDLE, BUSY} state_t;

  state_t          state_reg;
  logic [7:0]      wait_cnt1_reg;
  logic [7:0]      wait_cnt2_reg;
  logic            rr_last_reg;   // 0: master 1 granted last, 1: master 2

  logic            starved1;
  logic            starved2;
  logic [1:0]      rr_pick;       // round-robin winner when 1 and 2 tie
  logic [1:0]      winner;
  logic            sel_we;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;
  logic [MW-1:0]   sel_wmask;

  assign starved1 = m1_req_i && (wait_cnt1_reg >= LIMIT);
  assign starved2 = m2_req_i && (wait_cnt2_reg >= LIMIT);
  assign rr_pick  = rr_last_reg ? 2'd1 : 2'd2;

  always_comb begin
    winner = NONE;
    if (starved1 && starved2) winner = rr_pick;
    else if (starved1)        winner = 2'd1;
    else if (starved2)        winner = 2'd2;
    else if (m0_req_i)        winner = 2'd0;
    else if (m1_req_i && m2_req_i) winner = rr_pick;
    else if (m1_req_i)        winner = 2'd1;
    else if (m2_req_i)        winner = 2'd2;
  end

  always_comb begin
    sel_we    = m0_we_i;
    sel_addr  = m0_addr_i;
    sel_wdata = m0_wdata_i;
    sel_wmask = m0_wmask_i;
    case (winner)
      2'd1: begin
        sel_we = m1_we_i; sel_addr = m1_addr_i;
        sel_wdata = m1_wdata_i; sel_wmask = m1_wmask_i;
      end
      2'd2: begin
        sel_we = m2_we_i; sel_addr = m2_addr_i;
        sel_wdata = m2_wdata_i; sel_wmask = m2_wmask_i;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset_i) begin
    if (reset_i) begin
      state_reg     <= IDLE;
      mem_req_o     <= 1'b0;
      mem_we_o      <= 1'b0;
      mem_addr_o    <= '0;
      mem_wdata_o   <= '0;
      mem_wmask_o   <= '0;
      grant_o       <= NONE;
      wait_cnt1_reg <= 8'd0;
      wait_cnt2_reg <= 8'd0;
      rr_last_reg   <= 1'b1;   // master 2 "last", so master 1 wins the first tie
    end else begin
      case (state_reg)
        IDLE: begin
          if (winner != NONE) begin
            state_reg   <= BUSY;
            mem_req_o   <= 1'b1;
            grant_o     <= winner;
            mem_we_o    <= sel_we;
            mem_addr_o  <= sel_addr;
            mem_wdata_o <= sel_wdata;
            mem_wmask_o <= sel_wmask;
            case (winner)
              2'd0: begin
                // Waiting masters accumulate credit against video grants.
                if (m1_req_i && wait_cnt1_reg < LIMIT) wait_cnt1_reg <= wait_cnt1_reg + 8'd1;
                if (m2_req_i && wait_cnt2_reg < LIMIT) wait_cnt2_reg <= wait_cnt2_reg + 8'd1;
              end
              2'd1: begin
                wait_cnt1_reg <= 8'd0;
                rr_last_reg   <= 1'b0;
              end
              default: begin
                wait_cnt2_reg <= 8'd0;
                rr_last_reg   <= 1'b1;
              end
            endcase
          end
        end
        BUSY: begin
          if (mem_ack_i) begin
            state_reg <= IDLE;
            mem_req_o <= 1'b0;
            grant_o   <= NONE;
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

  // Completion is passed straight through; an ack seen in IDLE is ignored.
  assign m0_ack_o = (state_reg == BUSY) && (grant_o == 2'd0) && mem_ack_i;
  assign m1_ack_o = (state_reg == BUSY) && (grant_o == 2'd1) && mem_ack_i;
  assign m2_ack_o = (state_reg == BUSY) && (grant_o == 2'd2) && mem_ack_i;

  assign m0_rdata_o = mem_rdata_i;
  assign m1_rdata_o = mem_rdata_i;
  assign m2_rdata_o = mem_rdata_i;

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Three-port arbiter that shares the single SDRAM controller command port inside `xgsoc` among the video framebuffer fetcher, the CPU bus, and an auxiliary DMA master. Video has fixed top priority. CPU and DMA alternate round-robin. A per-master starvation counter ensures CPU and DMA make progress under continuous video load. The block sits between the master-side bus muxes and the SDRAM controller and handles exactly one outstanding transaction at a time.

## Interface
- `ADDR_WIDTH`, default 22: word address width (16 MiB / 32-bit words).
- `DATA_WIDTH`, default 32: data width.
- `STARVE_LIMIT`, default 8: number of video grants after which a waiting CPU/DMA master outranks video; valid range 1..255.

Ports (`N` = 0 video, 1 CPU, 2 DMA):
- `clk`  in  1: single clock. All logic is on the rising edge.
- `reset_i`  in  1: asynchronous, active-high reset.
- `mN_req_i`  in  1: request. Held high, with its command stable, until `mN_ack_o`.
- `mN_we_i`  in  1: 1 = write, 0 = read.
- `mN_addr_i`  in  ADDR_WIDTH: word address.
- `mN_wdata_i`  in  DATA_WIDTH: write data.
- `mN_wmask_i`  in  DATA_WIDTH/8: byte enables.
- `mN_ack_o`  out  1: one-cycle completion pulse.
- `mN_rdata_o`  out  DATA_WIDTH: read data, valid only while `mN_ack_o` is high.
- `mem_req_o`  out  1: command valid to the SDRAM controller.
- `mem_we_o`, `mem_addr_o`, `mem_wdata_o`, `mem_wmask_o`  out: latched command fields.
- `mem_ack_i`  in  1: one-cycle completion pulse from the controller.
- `mem_rdata_i`  in  DATA_WIDTH: read data, valid with `mem_ack_i`.
- `grant_o`  out  2: current owner (0/1/2), or 3 when idle.

## Operation
- FSM states: IDLE and BUSY.
- **IDLE:** if any `mN_req_i` is high, select a winner, register its command into the `mem_*` registers, set `mem_req_o`=1 and `grant_o`=N, then go to BUSY. If no request is high, stay in IDLE.
- **Winner selection**, in priority order:
  - (a) a starved master among 1/2, i.e. `wait_cnt` ≥ STARVE_LIMIT. If both are starved, the round-robin pointer decides.
  - (b) master 0.
  - (c) masters 1/2 by round-robin: the one not granted last wins a tie.
- **BUSY:** hold `mem_req_o` and all `mem_*` fields constant until `mem_ack_i`. On `mem_ack_i`:
  - `mN_ack_o` of the granted master = `mem_ack_i` (combinational, same cycle).
  - Go to IDLE, set `mem_req_o`=0 and `grant_o`=3.
- `mN_rdata_o` is `mem_rdata_i` broadcast to all three masters. It is qualified only by the master's own ack.
- **Starvation counters:** `wait_cnt1` and `wait_cnt2`, each 8-bit.
  - On each grant to master 0, the counter of each of masters 1/2 whose req is high increments, saturating at STARVE_LIMIT.
  - A master's counter clears when that master is granted.
- **Round-robin pointer `rr_last`:** updated only on a grant to master 1 or 2.
- **Master contract:** `req` sampled in the cycle after its ack is treated as a new request. Masters deassert req on the edge that ends their ack cycle.
- `mem_ack_i` while in IDLE is ignored: no `mN_ack_o` is generated and there is no state change.
- A master dropping req while BUSY is a protocol violation. The transaction still completes and is acknowledged.
- **Reset** (asynchronous, mid-operation included):
  - State → IDLE.
  - `mem_req_o`=0 and `grant_o`=3 immediately.
  - `mem_*` data fields = 0; counters = 0.
  - `rr_last` = master 2, so master 1 wins the first tie.
  - An in-flight transaction is abandoned and no ack is issued for it. The SDRAM controller shares `reset_i`.

## Timing
- Reset values: `mem_req_o`=0, `mem_we_o`=0, `mem_addr_o`=0, `mem_wdata_o`=0, `mem_wmask_o`=0, `grant_o`=3. All `mN_ack_o`=0 because state is IDLE.
- Request accept: req high at edge k while IDLE → `mem_req_o`=1 from cycle k+1.
- Completion: `mem_ack_i` in cycle m → `mN_ack_o` in cycle m (zero added latency). Back in IDLE at m+1.
- Back-to-back: earliest next `mem_req_o` is cycle m+2. There is one dead IDLE cycle between transactions.
- Arbitration overhead per transaction: 2 cycles, plus the controller latency.
- Simultaneous new request and ack completion: the new request is evaluated only in the following IDLE cycle.

## Test plan
1. **CPU single read:** `m1_req_i`=1, addr 0x000100, `we`=0; controller acks 5 cycles after `mem_req_o` with 0xDEADBEEF → `mem_addr_o`=0x000100 one cycle after the request; `m1_ack_o` pulses one cycle with `m1_rdata_o`=0xDEADBEEF; `grant_o` goes 1 → 3.
2. **Write with mask:** `m2` write, addr 0x3FFFFF, data 0x12345678, `wmask` 4'b0011 → `mem_we_o`=1 and the fields are forwarded exactly; `m2_ack_o` pulses once.
3. **Round-robin:** all three masters request continuously for 6 transactions; video requests only for the first → grant order 0,1,2,1,2,1.
4. **Starvation:** STARVE_LIMIT=4; video requests continuously and CPU requests from the start → CPU granted after exactly 4 video grants, then video resumes; `wait_cnt1` is back to 0.
5. **Reset mid-transaction:** assert `reset_i` while BUSY, not aligned to a clock edge → `mem_req_o`=0 and `grant_o`=3 before the next edge; after release, a late `mem_ack_i` produces no `mN_ack_o`.
6. **Spurious ack in IDLE:** pulse `mem_ack_i` with no request active → all `mN_ack_o` stay 0 and `grant_o` stays 3.
